instruction_memory_loader: RTL and testbench

- Write-side counterpart of the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory's write port at consecutive word addresses, starting at a base address.
- Used at boot/test time to program the memory before the core fetches from it.

---
 rtl/instruction_memory_loader_if.sv | 27 ++
 rtl/instruction_memory_loader.sv | 121 ++++++++++++
 tb/tb_instruction_memory_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream and memory-write signal bundle for the instruction memory loader.
// The slave modport is the loader; the master modport is the stream source / memory observer.
interface instruction_memory_loader_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  Start;
  logic [15:0]           WordCount;
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  WriteEnable;
  logic [ADDR_WIDTH-1:0] WriteAddress;
  logic [31:0]           WriteData;
  logic                  Busy;
  logic                  Done;
  logic                  Error;

  modport slave (
    input  Start, WordCount, ByteIn, ByteValid,
    output ByteReady, WriteEnable, WriteAddress, WriteData, Busy, Done, Error
  );

  modport master (
    output Start, WordCount, ByteIn, ByteValid,
    input  ByteReady, WriteEnable, WriteAddress, WriteData, Busy, Done, Error
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to
// consecutive instruction memory word addresses starting at BASE_ADDRESS.
module instruction_memory_loader #(
  parameter int                    ADDR_WIDTH   = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STEP    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1},
  parameter int                    MAX_WORDS    = 256
) (
  input logic                         Clock,
  input logic                         Reset,
  instruction_memory_loader_if.slave  bus
);

  localparam logic [15:0] MAX_WORDS_W = 16'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [15:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  error_q, error_d;

  // State and datapath registers; reset drops any partially assembled word.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 16'd0;
      count_q    <= 16'd0;
      addr_q     <= BASE_ADDRESS;
      data_q     <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      error_q    <= error_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    count_d    = count_q;
    addr_d     = addr_q;
    data_d     = data_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          count_d    = bus.WordCount;
          error_d    = 1'b0;
          addr_d     = BASE_ADDRESS;
          word_cnt_d = 16'd0;
          byte_cnt_d = 2'd0;
          if (bus.WordCount == 16'd0) begin
            state_d = S_FINISH;
          end else if (bus.WordCount > MAX_WORDS_W) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (bus.ByteValid) begin
          data_d[{byte_cnt_q, 3'b000} +: 8] = bus.ByteIn;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 16'd1;
        if (word_cnt_d == count_q) begin
          state_d = S_FINISH;
        end else begin
          // Wraps modulo 2^ADDR_WIDTH by construction.
          addr_d  = addr_q + ADDR_STEP;
          state_d = S_COLLECT;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ByteReady    = (state_q == S_COLLECT);
  assign bus.WriteEnable  = (state_q == S_WRITE);
  assign bus.Done         = (state_q == S_FINISH);
  assign bus.Busy         = (state_q != S_IDLE);
  assign bus.WriteAddress = addr_q;
  assign bus.WriteData    = data_q;
  assign bus.Error        = error_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed and randomized loads checked against a word-list model built from the
// byte stream: word i = bytes 4i..4i+3 little-endian at address i, written the cycle after byte 4i+3.
module tb_instruction_memory_loader;

  localparam int MAXW = 256;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  bit   clk_en = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  instruction_memory_loader_if #(.ADDR_WIDTH(64)) bus ();

  instruction_memory_loader #(.ADDR_WIDTH(64)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_en) Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  logic [7:0]  stim [0:63];
  logic [63:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc  [$];
  int          acc_cyc [$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_cnt = 0;
  int          start_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe the memory write port and status pulses mid-cycle.
  always @(negedge Clock) begin
    if (bus.WriteEnable === 1'b1) begin
      wr_addr.push_back(bus.WriteAddress);
      wr_data.push_back(bus.WriteData);
      wr_cyc.push_back(cyc);
      chk("ready_low_in_write", 64'(bus.ByteReady), 64'd0);
    end
    if (bus.Done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.Busy === 1'b1) busy_cnt++;
  end

  // Offer one byte until a handshake completes; called just after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    logic rdy;
    bus.ByteIn = b;
    bus.ByteValid = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge Clock);
      rdy = bus.ByteReady;
      @(posedge Clock);
      #1;
      if (rdy) begin
        got = 1'b1;
        acc_cyc.push_back(cyc);
      end
    end
    bus.ByteValid = 1'b0;
    if (!got) chk("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic clear_obs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc_cyc.delete();
    done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic run_load(input logic [15:0] wc, input int gap_at, input int gap_len,
                          input bit pulse_start, input string tag);
    bit legal;
    int nw;
    int t;
    logic [31:0] w;
    clear_obs();
    legal = (int'(wc) <= MAXW);
    nw = legal ? int'(wc) : 0;
    @(negedge Clock);
    bus.Start = 1'b1;
    bus.WordCount = wc;
    @(posedge Clock);
    #1;
    start_cyc = cyc;
    bus.Start = 1'b0;
    for (int i = 0; i < nw * 4; i++) begin
      if (pulse_start && i == 2) begin
        bus.Start = 1'b1;
        bus.WordCount = 16'd5;
      end
      send_byte(stim[i]);
      bus.Start = 1'b0;
      if (i == gap_at && gap_len > 0) begin
        repeat (gap_len) @(posedge Clock);
        #1;
      end
    end
    t = 0;
    while (done_cnt == 0 && t < 40) begin
      @(negedge Clock);
      t++;
    end
    repeat (2) @(negedge Clock);

    chk({tag, "_nwrites"}, 64'(wr_data.size()), 64'(nw));
    for (int i = 0; i < nw && i < wr_data.size(); i++) begin
      w = 32'(stim[4*i]) + 32'(stim[4*i+1]) * 32'd256 +
          32'(stim[4*i+2]) * 32'd65536 + 32'(stim[4*i+3]) * 32'd16777216;
      chk({tag, "_addr"}, wr_addr[i], 64'(i));
      chk({tag, "_data"}, 64'(wr_data[i]), 64'(w));
      if (acc_cyc.size() > 4*i+3) chk({tag, "_wr_lat"}, 64'(wr_cyc[i]), 64'(acc_cyc[4*i+3]));
    end
    chk({tag, "_done_cnt"}, 64'(done_cnt), legal ? 64'd1 : 64'd0);
    if (nw > 0 && wr_cyc.size() == nw && done_cnt == 1) begin
      chk({tag, "_done_lat"}, 64'(done_cyc), 64'(wr_cyc[nw-1] + 1));
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(done_cyc - start_cyc + 1));
      chk({tag, "_hold"}, 64'(bus.WriteData), 64'(wr_data[nw-1]));
    end
    if (nw == 0) chk({tag, "_busy_cycles"}, 64'(busy_cnt), legal ? 64'd1 : 64'd0);
    chk({tag, "_error"}, 64'(bus.Error), legal ? 64'd0 : 64'd1);
    chk({tag, "_busy_end"}, 64'(bus.Busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    64'(bus.WriteEnable), 64'd0);
    chk({tag, "_rdy"},   64'(bus.ByteReady), 64'd0);
    chk({tag, "_busy"},  64'(bus.Busy), 64'd0);
    chk({tag, "_done"},  64'(bus.Done), 64'd0);
    chk({tag, "_err"},   64'(bus.Error), 64'd0);
    chk({tag, "_addr"},  bus.WriteAddress, 64'd0);
    chk({tag, "_data"},  64'(bus.WriteData), 64'd0);
  endtask

  initial begin
    int wc;
    bus.Start = 1'b0;
    bus.WordCount = 16'd0;
    bus.ByteIn = 8'd0;
    bus.ByteValid = 1'b0;

    // Reset with the clock stopped: outputs must clear immediately.
    #2;
    Reset = 1'b0;
    #1;
    check_reset_outputs("por");
    #2;
    Reset = 1'b1;
    #2;
    clk_en = 1'b1;
    repeat (2) @(negedge Clock);

    // Two-word program, back-to-back bytes.
    {stim[0], stim[1], stim[2], stim[3]} = {8'h13, 8'h05, 8'hA0, 8'h00};
    {stim[4], stim[5], stim[6], stim[7]} = {8'hB3, 8'h85, 8'hC5, 8'h00};
    run_load(16'd2, -1, 0, 1'b0, "two_words");

    // Same stream with a 3-cycle ByteValid gap after byte 1.
    run_load(16'd2, 1, 3, 1'b0, "gap3");

    run_load(16'd0, -1, 0, 1'b0, "zero");
    run_load(16'd257, -1, 0, 1'b0, "illegal");
    {stim[0], stim[1], stim[2], stim[3]} = {8'h11, 8'h22, 8'h33, 8'h44};
    run_load(16'd1, -1, 0, 1'b0, "after_err");

    // Reset mid-word discards the partial bytes.
    clear_obs();
    @(negedge Clock);
    bus.Start = 1'b1;
    bus.WordCount = 16'd1;
    @(posedge Clock);
    #1;
    bus.Start = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge Clock);
    clk_en = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    chk("mid_rst_nowrite", 64'(wr_data.size()), 64'd0);
    #2;
    Reset = 1'b1;
    #2;
    clk_en = 1'b1;
    repeat (2) @(negedge Clock);
    {stim[0], stim[1], stim[2], stim[3]} = {8'h6F, 8'h00, 8'h00, 8'h00};
    run_load(16'd1, -1, 0, 1'b0, "post_rst");

    // Start pulsed while collecting must be ignored.
    {stim[0], stim[1], stim[2], stim[3]} = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(16'd1, -1, 0, 1'b1, "start_busy");

    // Randomized loads with random gaps.
    for (int r = 0; r < 6; r++) begin
      wc = int'($urandom_range(4, 1));
      for (int i = 0; i < 64; i++) stim[i] = 8'($urandom);
      run_load(16'(wc), int'($urandom_range(wc * 4 - 1, 0)), int'($urandom_range(3, 0)),
               1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
